router_pkt_src: RTL and testbench
=================================

Name: router_pkt_src

Overview:
- Packet source that sits directly upstream of the router top level and drives its data_in/pkt_valid inputs, honouring busy.
- The host loads payload words into a small internal buffer, then issues a send command with a destination port.
- The block serialises header, payload and parity words onto the 3-bit router input bus.

Parameters:
- DEPTH, 16, payload buffer depth in 3-bit words; also the maximum payload length per packet.
- CW, 5, width of the payload count; must satisfy 2^CW > DEPTH.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- resetn  input  1  synchronous, active-high reset (port name kept from the codebase; asserted = 1).
- pl_wr  input  1  payload write strobe; accepted only in IDLE with count < DEPTH.
- pl_data  input  3  payload word written at the current count position.
- send  input  1  start-packet command; sampled only in IDLE.
- dest  input  2  destination port 0..2, sampled with send; 3 is illegal.
- busy  input  1  router busy; while high, the current word is held.
- data_out  output  3  word to the router data_in.
- pkt_valid  output  1  to the router pkt_valid; high for header and payload, low for parity.
- idle  output  1  high in IDLE.
- done  output  1  one-cycle pulse after the parity word is accepted.
- err  output  1  one-cycle pulse on an illegal send or buffer overflow.
- count  output  CW  number of buffered payload words.

Behaviour:
- Reset values: data_out=0, pkt_valid=0, idle=1, done=0, err=0, count=0, state=IDLE, parity accumulator=0, read index=0.
- Transfer rule: a word is accepted on any rising edge where state is HEADER, PAYLOAD or PARITY and busy=0. When busy=1, data_out and pkt_valid hold their values unchanged.
- Buffer writes:
  - pl_wr in IDLE with count<DEPTH stores pl_data at buf[count] and increments count.
  - pl_wr with count==DEPTH is dropped, count is unchanged, and err pulses.
  - pl_wr outside IDLE is ignored silently.
  - If pl_wr and send occur in the same cycle, the write happens and send is ignored.
- State IDLE:
  - send with count>=1 and dest!=3 latches dest, clears the read index, and moves to HEADER next cycle. That cycle shows data_out={1'b0,dest}, pkt_valid=1, parity=that header word.
  - send with count==0 or dest==3 pulses err and stays in IDLE.
- State HEADER: on transfer, move to PAYLOAD; data_out=buf[0]; parity^=header word is already included.
- State PAYLOAD:
  - On transfer, parity^=current word and the index increments.
  - If the word just accepted was index count-1: move to PARITY; data_out=final parity (including that word); pkt_valid=0.
  - Otherwise: data_out=buf[index+1].
- State PARITY: on transfer, return to IDLE; count=0; data_out=0; pkt_valid=0; done=1 for exactly one cycle.
- Parity rule: the parity word is the bitwise XOR of the header and all payload words.
- Latency: with busy held low, a packet of N payload words occupies N+2 cycles on the bus. done asserts on cycle N+3 after the send edge.
- busy may rise or fall on any cycle, including during the parity word. No word is ever dropped or duplicated.
- resetn mid-packet: on the next edge, all state returns to reset values and the buffer count is cleared. A partial packet is abandoned with pkt_valid=0.
- idle is a combinational decode of state==IDLE.

Test Plan:
- Load 101, 110; send dest=1, busy=0 -> bus shows 001(pv=1), 101(pv=1), 110(pv=1), 010(pv=0); done pulses next cycle; count=0.
- Same packet with busy=1 for 3 cycles during word 101 -> 101 held for 4 cycles with pv=1; sequence and parity 010 unchanged.
- send with count=0, and separately send with dest=3 after loading 1 word -> err pulses once each; pkt_valid stays 0; idle stays 1; count preserved.
- Write 17 words with DEPTH=16 -> count=16; err on the 17th; a following send emits 16 payload words and the correct XOR parity.
- Assert resetn during payload word 2 of 4 -> next cycle pkt_valid=0, data_out=0, count=0, idle=1; a fresh packet then sends correctly.
- Single-word payload 111 to dest=2 -> 010(pv=1), 111(pv=1), 101(pv=0); pl_wr pulsed during sending is ignored (count stays 0 after done).

Source files
------------

// File: rtl/router_pkt_src.sv
// Packet source feeding the router: buffers host payload words, then serialises
// header, payload and XOR parity onto the 3-bit bus while honouring busy.
module router_pkt_src #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pl_wr,
    input  logic [2:0]    pl_data,
    input  logic          send,
    input  logic [1:0]    dest,
    input  logic          busy,
    output logic [2:0]    data_out,
    output logic          pkt_valid,
    output logic          idle,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    data_q, data_d;
    logic [2:0]    parity_q, parity_d;
    logic          pv_q, pv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] idx_inc;
    logic          wr_en;
    logic [2:0]    buf_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        pv_d     = pv_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        count_d  = count_q;
        idx_d    = idx_q;
        idx_inc  = idx_q + CW'(1);
        wr_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pl_wr) begin
                    if (count_q < CW'(DEPTH)) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (send) begin
                    if (count_q == '0 || dest == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_HEADER;
                        data_d   = {1'b0, dest};
                        parity_d = {1'b0, dest};
                        pv_d     = 1'b1;
                        idx_d    = '0;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d = S_PAYLOAD;
                    data_d  = buf_q[0];
                end
            end
            S_PAYLOAD: begin
                // data_q always holds buf[idx], so it is the word being accepted
                if (!busy) begin
                    parity_d = parity_q ^ data_q;
                    if (idx_inc == count_q) begin
                        state_d = S_PARITY;
                        data_d  = parity_q ^ data_q;
                        pv_d    = 1'b0;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = buf_q[idx_inc[AW-1:0]];
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    data_d  = '0;
                    pv_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            parity_q <= '0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Payload storage carries no reset; count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[count_q[AW-1:0]] <= pl_data;
        end
    end

    assign data_out  = data_q;
    assign pkt_valid = pv_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;
    assign idle      = (state_q == S_IDLE);

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: directed vector table, multi-cycle corner sequences,
// and random packets checked against a word-list model of the bus.
module tb_router_pkt_src;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pl_wr;
    logic [2:0]    pl_data;
    logic          send;
    logic [1:0]    dest;
    logic          busy;
    logic [2:0]    data_out;
    logic          pkt_valid;
    logic          idle;
    logic          done;
    logic          err;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    router_pkt_src #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .resetn(resetn), .pl_wr(pl_wr), .pl_data(pl_data),
        .send(send), .dest(dest), .busy(busy), .data_out(data_out),
        .pkt_valid(pkt_valid), .idle(idle), .done(done), .err(err), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic [47:0] words;
        logic [1:0] dst;
        logic [2:0] par;
        int         bmode;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_par(input int n, input logic [47:0] w, input logic [1:0] d);
        logic [2:0] p;
        p = {1'b0, d};
        for (int i = 0; i < n; i++) p ^= w[3*i +: 3];
        return p;
    endfunction

    task automatic do_reset();
        resetn = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
    endtask

    task automatic load_words(input int n, input logic [47:0] w);
        for (int i = 0; i < n; i++) begin
            pl_wr   = 1'b1;
            pl_data = w[3*i +: 3];
            @(posedge clock);
            @(negedge clock);
        end
        pl_wr = 1'b0;
        chk("count_after_load", 32'(count), 32'(n));
    endtask

    // bmode: 0 busy low, 1 random busy + pl_wr noise, 2 busy for 3 cycles on word 1, 3 pl_wr noise only
    task automatic run_packet(input int n, input logic [47:0] w, input logic [1:0] d,
                              input logic [2:0] par, input int bmode);
        logic [2:0] exp_w [18];
        logic       exp_pv [18];
        int k, cyc, held;
        exp_w[0]  = {1'b0, d};
        exp_pv[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_w[1+i]  = w[3*i +: 3];
            exp_pv[1+i] = 1'b1;
        end
        exp_w[n+1]  = par;
        exp_pv[n+1] = 1'b0;

        send = 1'b1;
        dest = d;
        @(posedge clock);
        @(negedge clock);
        send = 1'b0;
        k = 0; cyc = 0; held = 0;
        while (k < n + 2 && cyc < 400) begin
            chk($sformatf("word%0d", k), 32'(data_out), 32'(exp_w[k]));
            chk($sformatf("pv%0d", k), 32'(pkt_valid), 32'(exp_pv[k]));
            chk("idle_busy_phase", 32'(idle), 32'(0));
            case (bmode)
                1:       busy = ($urandom_range(0, 99) < 35);
                2:       busy = (k == 1 && held < 3);
                default: busy = 1'b0;
            endcase
            if (busy) held++;
            pl_wr   = (bmode == 1 || bmode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            pl_data = 3'($urandom);
            @(posedge clock);
            if (!busy) k++;
            cyc++;
            @(negedge clock);
        end
        pl_wr = 1'b0;
        busy  = 1'b0;
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("FAIL packet_timeout actual=%0d words expected=%0d", k, n + 2);
        end
        chk("done_pulse", 32'(done), 32'(1));
        chk("pv_after", 32'(pkt_valid), 32'(0));
        chk("data_after", 32'(data_out), 32'(0));
        chk("count_after", 32'(count), 32'(0));
        chk("idle_after", 32'(idle), 32'(1));
        @(posedge clock);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    vec_t vecs [5];

    initial begin
        logic [47:0] w;
        int n;
        logic [1:0] d;

        vecs[0] = '{n: 2, words: {42'b0, 3'b110, 3'b101}, dst: 2'd1, par: 3'b010, bmode: 0};
        vecs[1] = '{n: 2, words: {42'b0, 3'b110, 3'b101}, dst: 2'd1, par: 3'b010, bmode: 2};
        vecs[2] = '{n: 1, words: {45'b0, 3'b111},         dst: 2'd2, par: 3'b101, bmode: 3};
        vecs[3] = '{n: 3, words: {39'b0, 3'b100, 3'b001, 3'b011}, dst: 2'd0, par: 3'b110, bmode: 0};
        vecs[4] = '{n: 1, words: {45'b0, 3'b000},         dst: 2'd1, par: 3'b001, bmode: 1};

        resetn = 1'b1; pl_wr = 1'b0; pl_data = '0; send = 1'b0; dest = '0; busy = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        chk("rst_data", 32'(data_out), 32'(0));
        chk("rst_pv", 32'(pkt_valid), 32'(0));
        chk("rst_idle", 32'(idle), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_count", 32'(count), 32'(0));

        for (int v = 0; v < 5; v++) begin
            load_words(vecs[v].n, vecs[v].words);
            run_packet(vecs[v].n, vecs[v].words, vecs[v].dst, vecs[v].par, vecs[v].bmode);
        end

        // send with empty buffer
        send = 1'b1; dest = 2'd0;
        @(posedge clock); @(negedge clock);
        send = 1'b0;
        chk("err_empty", 32'(err), 32'(1));
        chk("idle_empty", 32'(idle), 32'(1));
        chk("pv_empty", 32'(pkt_valid), 32'(0));
        @(posedge clock); @(negedge clock);
        chk("err_empty_once", 32'(err), 32'(0));

        // send with illegal destination
        load_words(1, 48'o5);
        send = 1'b1; dest = 2'd3;
        @(posedge clock); @(negedge clock);
        send = 1'b0;
        chk("err_dest3", 32'(err), 32'(1));
        chk("idle_dest3", 32'(idle), 32'(1));
        chk("pv_dest3", 32'(pkt_valid), 32'(0));
        chk("count_dest3", 32'(count), 32'(1));
        @(posedge clock); @(negedge clock);
        chk("err_dest3_once", 32'(err), 32'(0));
        do_reset();
        chk("count_cleared", 32'(count), 32'(0));

        // overflow: 17th write dropped
        w = {$urandom, $urandom};
        load_words(16, w);
        pl_wr = 1'b1; pl_data = 3'b111;
        @(posedge clock); @(negedge clock);
        pl_wr = 1'b0;
        chk("err_overflow", 32'(err), 32'(1));
        chk("count_overflow", 32'(count), 32'(16));
        @(posedge clock); @(negedge clock);
        chk("err_overflow_once", 32'(err), 32'(0));
        run_packet(16, w, 2'd0, ref_par(16, w, 2'd0), 1);

        // reset while payload word 2 of 4 is on the bus
        w = {36'b0, 3'b100, 3'b011, 3'b010, 3'b001};
        load_words(4, w);
        send = 1'b1; dest = 2'd2;
        @(posedge clock); @(negedge clock);
        send = 1'b0;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("mid_word2", 32'(data_out), 32'(3'b010));
        resetn = 1'b1;
        @(posedge clock); @(negedge clock);
        resetn = 1'b0;
        chk("mid_rst_pv", 32'(pkt_valid), 32'(0));
        chk("mid_rst_data", 32'(data_out), 32'(0));
        chk("mid_rst_count", 32'(count), 32'(0));
        chk("mid_rst_idle", 32'(idle), 32'(1));
        load_words(vecs[0].n, vecs[0].words);
        run_packet(vecs[0].n, vecs[0].words, vecs[0].dst, vecs[0].par, 0);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, DEPTH);
            w = {$urandom, $urandom};
            d = 2'($urandom_range(0, 2));
            load_words(n, w);
            run_packet(n, w, d, ref_par(n, w, d), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
